// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display.
// Cathode patterns are active-low with C[0]=a .. C[6]=g and C[7]=dp (dp off in every pattern).
package seg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Indexed by digit_idx_t: slot 0 drives A[0] .. slot 3 drives A[3]; A[7:4] stay high.
  localparam logic [3:0][7:0] ANODE_SEL = {8'hF7, 8'hFB, 8'hFD, 8'hFE};

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; values above 9 render as a dash.
module seg7_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit time-multiplexed seven-segment driver with a 1 Hz blinking hour/minute dot.
// Optional macro LEADING_ZERO_BLANK_EN turns off the hour-tens digit when it is zero.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DP_HALF_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       display_en,
  input  logic [3:0] u_min,
  input  logic [2:0] z_min,
  input  logic [3:0] u_hour,
  input  logic [1:0] z_hour,
  output logic [7:0] A,
  output logic [7:0] C
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (DP_HALF_FRAMES > 1) ? $clog2(DP_HALF_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(DP_HALF_FRAMES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [FRM_W-1:0] r_frame_cnt;
  digit_idx_t       r_idx;
  logic             r_dp;
  logic [3:0]       r_sh_umin, r_sh_zmin, r_sh_uhour, r_sh_zhour;
  logic [7:0]       r_a, r_c;

  logic             w_tick;
  logic             w_frame_end;
  logic [3:0]       w_digit;
  logic [7:0]       w_seg;
  logic [7:0]       w_a_next, w_c_next;

  assign w_tick      = (r_cnt == CNT_LAST);
  assign w_frame_end = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  // The whole frame is captured at once so a digit never mixes old and new time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_umin  <= '0;
      r_sh_zmin  <= '0;
      r_sh_uhour <= '0;
      r_sh_zhour <= '0;
    end else if (w_frame_end) begin
      r_sh_umin  <= u_min;
      r_sh_zmin  <= {1'b0, z_min};
      r_sh_uhour <= u_hour;
      r_sh_zhour <= {2'b00, z_hour};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_dp        <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FRM_LAST) begin
        r_frame_cnt <= '0;
        r_dp        <= ~r_dp;
      end else begin
        r_frame_cnt <= r_frame_cnt + FRM_W'(1);
      end
    end
  end

  always_comb begin
    w_digit = r_sh_umin;
    case (r_idx)
      2'd0:    w_digit = r_sh_umin;
      2'd1:    w_digit = r_sh_zmin;
      2'd2:    w_digit = r_sh_uhour;
      default: w_digit = r_sh_zhour;
    endcase
  end

  seg7_decoder u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  always_comb begin
    w_c_next = w_seg;
    // The separator dot sits after the hour-units digit.
    if ((r_idx == 2'd2) && r_dp) w_c_next[7] = 1'b0;

    w_a_next = ANODE_SEL[r_idx];
`ifdef LEADING_ZERO_BLANK_EN
    if ((r_idx == 2'd3) && (r_sh_zhour == 4'd0)) w_a_next = ANODE_OFF;
`endif
    if (!display_en) w_a_next = ANODE_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= ANODE_OFF;
      r_c <= SEG_OFF;
    end else begin
      r_a <= w_a_next;
      r_c <= w_c_next;
    end
  end

  assign A = r_a;
  assign C = r_c;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboarded bench for seg_display_mux at SCAN_DIV=4, DP_HALF_FRAMES=2 (16-clock frames).
module tb_seg_display_mux;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] c;
  } exp_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       display_en = 1'b1;
  logic [3:0] u_min = 4'd4;
  logic [2:0] z_min = 3'd3;
  logic [3:0] u_hour = 4'd2;
  logic [1:0] z_hour = 2'd1;
  logic [7:0] A, C;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   en_lo = -1;
  int   en_hi = -1;
  exp_t sb[$];
  exp_t mon_e;

  seg_display_mux #(
    .SCAN_DIV       (4),
    .DP_HALF_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .display_en (display_en),
    .u_min      (u_min),
    .z_min      (z_min),
    .u_hour     (u_hour),
    .z_hour     (z_hour),
    .A          (A),
    .C          (C)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release; the output after edge n is expected at cycle n.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int at, input logic [7:0] ga, input logic [7:0] gc,
                     input logic [7:0] ea, input logic [7:0] ec);
    checks++;
    if (ga !== ea || gc !== ec) begin
      failures++;
      $display("FAIL %s cyc=%0d A=%h C=%h expected A=%h C=%h", name, at, ga, gc, ea, ec);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL sb_missed cyc=%0d expected A=%h C=%h", mon_e.cyc, mon_e.a, mon_e.c);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        chk("scan", cyc, A, C, mon_e.a, mon_e.c);
      end
    end
  end

  // Push the 16 expected cycles of frame f; c0..c3 are the dp-off patterns of slots 0..3.
  task automatic push_frame(input int f, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3, input bit dp,
                            input bit blank3);
    logic [7:0] sel [4];
    logic [7:0] cs  [4];
    exp_t       e;
    sel = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    cs  = '{c0, c1, c2, c3};
    for (int s = 0; s < 4; s++) begin
      for (int k = 1; k <= 4; k++) begin
        e.cyc = 16 * f + 4 * s + k;
        e.a   = sel[s];
        e.c   = cs[s];
        if (s == 2 && dp) e.c[7] = 1'b0;
        if (s == 3 && blank3) e.a = 8'hFF;
        if (e.cyc >= en_lo && e.cyc <= en_hi) e.a = 8'hFF;
        sb.push_back(e);
      end
    end
  endtask

  task automatic go_cyc(input int n);
    for (int k = 0; k < 1000 && cyc < n; k++) @(negedge clk);
  endtask

  initial begin
    en_lo = 101;
    en_hi = 110;
    push_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, BLANK);
    push_frame(1, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 1'b0);
    push_frame(2, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, 1'b0);
    push_frame(3, 8'h90, 8'h92, 8'hB0, 8'hA4, 1'b1, 1'b0);
    push_frame(4, 8'h90, 8'h92, 8'hB0, 8'hA4, 1'b0, 1'b0);
    push_frame(5, 8'hBF, 8'h92, 8'hB0, 8'hC0, 1'b0, BLANK);
    push_frame(6, 8'hBF, 8'h92, 8'hB0, 8'hC0, 1'b1, BLANK);
    push_frame(7, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_hold", cyc, A, C, 8'hFF, 8'hFF);
    rst = 1'b1;

    go_cyc(38);
    u_min = 4'd9; z_min = 3'd5; u_hour = 4'd3; z_hour = 2'd2;
    go_cyc(70);
    u_min = 4'hC; z_hour = 2'd0;
    go_cyc(100);
    display_en = 1'b0;
    u_min = 4'd4; z_min = 3'd3; u_hour = 4'd2; z_hour = 2'd1;
    go_cyc(110);
    display_en = 1'b1;

    go_cyc(130);
    #1 rst = 1'b0;
    #1 chk("async_reset", cyc, A, C, 8'hFF, 8'hFF);
    @(negedge clk);
    chk("reset_hold2", cyc, A, C, 8'hFF, 8'hFF);
    en_lo = -1;
    en_hi = -1;
    push_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, BLANK);
    push_frame(1, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 1'b0);
    rst = 1'b1;

    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
